// File: rtl/uart_alu_top.sv
// rtl/uart_alu_top.sv - UART-driven packet ALU: echo, 32-bit add, 32-bit multiply
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   asynchronous active-low reset
//   rx_i  8N1 serial input, idle high (synchronized internally)
//   tx_o  8N1 serial output, idle high
// Bit time is 8*PRESCALE clocks. Results and echoed bytes queue in a small TX FIFO.

module uart_alu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module uart_alu_top #(
  parameter int PRESCALE      = 35,
  parameter int DATA_WIDTH    = 8,
  parameter int TX_FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);
  localparam int BT = 8 * PRESCALE;
  localparam int CW = $clog2(BT + 1);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'h88;

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  rx_state_t rx_state, rx_next;
  logic [CW-1:0]         rx_cnt;
  logic [BW-1:0]         rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift, rx_data;
  logic                  rx_meta, rx_s, rx_valid, rx_tick, rx_half;

  assign rx_tick = (rx_cnt == CW'(BT - 1));
  assign rx_half = (rx_cnt == CW'(BT / 2 - 1));

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == BW'(DATA_WIDTH - 1)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s) rx_next = RX_IDLE;   // framing error: hold off until line idles
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= rx_i;
      rx_s     <= rx_meta;
      rx_state <= rx_next;
      rx_valid <= 1'b0;
      rx_cnt   <= (rx_next != rx_state || rx_tick) ? '0 : rx_cnt + CW'(1);
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
        rx_bit   <= rx_bit + BW'(1);
      end
      if (rx_state == RX_STOP && rx_tick && rx_s) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_shift;
      end
    end
  end

  // ---------------- TX FIFO ----------------
  logic                  push_q, fifo_pop, fifo_empty;
  logic [DATA_WIDTH-1:0] push_data, fifo_rdata;

  uart_alu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

  // ---------------- TX ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t tx_state, tx_next;
  logic [CW-1:0]         tx_cnt;
  logic [BW-1:0]         tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  tx_tick;

  assign tx_tick = (tx_cnt == CW'(BT - 1));

  always_comb begin
    tx_next  = tx_state;
    fifo_pop = 1'b0;
    case (tx_state)
      TX_IDLE:  if (!fifo_empty) begin fifo_pop = 1'b1; tx_next = TX_START; end
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == BW'(DATA_WIDTH - 1)) tx_next = TX_STOP;
      TX_STOP: begin
        // Chain straight into the next start bit so queued bytes have no gap.
        if (tx_tick) begin
          if (!fifo_empty) begin fifo_pop = 1'b1; tx_next = TX_START; end
          else tx_next = TX_IDLE;
        end
      end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_next != tx_state || tx_tick) ? '0 : tx_cnt + CW'(1);
      if (fifo_pop) begin
        tx_shift <= fifo_rdata;
        tx_bit   <= '0;
      end else if (tx_state == TX_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
        tx_bit   <= tx_bit + BW'(1);
      end
    end
  end

  assign tx_o = (tx_state == TX_START) ? 1'b0 :
                (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  // ---------------- Packet parser / ALU ----------------
  typedef enum logic [2:0] {P_HDR0, P_HDR1, P_HDR2, P_HDR3, P_PAYLOAD, P_RESULT} p_state_t;
  p_state_t p_state, p_next;
  logic [7:0]  opcode, len_lsb;
  logic [15:0] remain, len_full, pay_len;
  logic [31:0] acc, operand, product;
  logic [23:0] opbuf;
  logic [1:0]  bcnt, rcnt;
  logic        have_op, is_alu;

  assign is_alu   = (opcode == OP_ADD) || (opcode == OP_MUL);
  assign len_full = {rx_data, len_lsb};
  assign pay_len  = (len_full < 16'd4) ? 16'd0 : len_full - 16'd4;
  assign operand  = {rx_data, opbuf};   // little-endian: newest byte is the MSB
  assign product  = acc * operand;

  always_comb begin
    p_next = p_state;
    case (p_state)
      P_HDR0:    if (rx_valid) p_next = P_HDR1;
      P_HDR1:    if (rx_valid) p_next = P_HDR2;
      P_HDR2:    if (rx_valid) p_next = P_HDR3;
      P_HDR3:    if (rx_valid) p_next = (pay_len != 16'd0) ? P_PAYLOAD :
                                        is_alu ? P_RESULT : P_HDR0;
      P_PAYLOAD: if (rx_valid && remain == 16'd1) p_next = is_alu ? P_RESULT : P_HDR0;
      P_RESULT:  if (rcnt == 2'd3) p_next = P_HDR0;
      default:   p_next = P_HDR0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_state   <= P_HDR0;
      opcode    <= '0;
      len_lsb   <= '0;
      remain    <= '0;
      acc       <= '0;
      opbuf     <= '0;
      bcnt      <= '0;
      rcnt      <= '0;
      have_op   <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      p_state <= p_next;
      push_q  <= 1'b0;
      case (p_state)
        P_HDR0: if (rx_valid) opcode <= rx_data;
        P_HDR2: if (rx_valid) len_lsb <= rx_data;
        P_HDR3: if (rx_valid) begin
          remain  <= pay_len;
          acc     <= '0;
          bcnt    <= '0;
          rcnt    <= '0;
          have_op <= 1'b0;
        end
        P_PAYLOAD: if (rx_valid) begin
          remain <= remain - 16'd1;
          if (opcode == OP_ECHO) begin
            push_q    <= 1'b1;
            push_data <= rx_data;
          end
          if (is_alu) begin
            opbuf <= {rx_data, opbuf[23:8]};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              have_op <= 1'b1;
              if (opcode == OP_ADD) acc <= acc + operand;
              else                  acc <= have_op ? product : operand;
            end
          end
        end
        P_RESULT: begin
          // Shift acc out LSB first; four shifts leave it at zero for the next packet.
          push_q    <= 1'b1;
          push_data <= acc[7:0];
          acc       <= {8'd0, acc[31:8]};
          rcnt      <= rcnt + 2'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_alu_top.sv
// tb/tb_uart_alu_top.sv - randomized and directed bench for uart_alu_top against a packet-level model
`timescale 1ns/1ps

module tb_uart_alu_top;
  localparam int PRESCALE = 2;
  localparam int BT       = 8 * PRESCALE;

  logic clk = 1'b0;
  logic rst;
  logic rx_i;
  logic tx_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] stream_q[$];  // good bytes delivered since last segment start
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] pkt_q[$];

  uart_alu_top #(.PRESCALE(PRESCALE), .DATA_WIDTH(8), .TX_FIFO_DEPTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (BT) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_i = b[k];
      repeat (BT) @(negedge clk);
    end
    rx_i = stop_bit;
    repeat (BT) @(negedge clk);
    rx_i = 1'b1;
    if (!stop_bit) repeat (2 * BT) @(negedge clk);
  endtask

  task automatic send_pkt();
    foreach (pkt_q[k]) begin
      send_bits(pkt_q[k], 1'b1);
      stream_q.push_back(pkt_q[k]);
    end
  endtask

  // Packet-level reference: walk the byte stream packet by packet.
  task automatic model_stream();
    int i, p, len;
    logic [31:0] acc, w;
    logic [7:0]  op;
    exp_q.delete();
    i = 0;
    while (i + 4 <= stream_q.size()) begin
      op  = stream_q[i];
      len = {stream_q[i+3], stream_q[i+2]};
      p   = (len < 4) ? 0 : len - 4;
      i  += 4;
      if (i + p > stream_q.size()) break;
      acc = 0;
      for (int n = 0; n < p / 4; n++) begin
        w = {stream_q[i+4*n+3], stream_q[i+4*n+2], stream_q[i+4*n+1], stream_q[i+4*n]};
        if (op == 8'hA0)  acc = acc + w;
        else if (n == 0)  acc = w;
        else              acc = acc * w;
      end
      if (op == 8'hEC) begin
        for (int k = 0; k < p; k++) exp_q.push_back(stream_q[i+k]);
      end else if (op == 8'hA0 || op == 8'h88) begin
        for (int k = 0; k < 4; k++) exp_q.push_back(acc[8*k +: 8]);
      end
      i += p;
    end
  endtask

  task automatic finish_seg(input string tag);
    int cyc;
    model_stream();
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < 20 * BT * 12) begin
      @(negedge clk);
      cyc++;
    end
    repeat (14 * BT) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), (k < got_q.size()) ? {24'd0, got_q[k]} : 32'h100,
            {24'd0, exp_q[k]});
    got_q.delete();
    stream_q.delete();
  endtask

  // TX monitor: decode 8N1 characters at mid-bit.
  initial begin : monitor
    logic [7:0] mb;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_o === 1'b0) begin
        repeat (BT / 2) @(negedge clk);
        check("tx_start_bit", tx_o, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (BT) @(negedge clk);
          mb[k] = tx_o;
        end
        repeat (BT) @(negedge clk);
        check("tx_stop_bit", tx_o, 1'b1);
        got_q.push_back(mb);
      end
    end
  end

  initial begin : main
    logic [7:0] op;
    int p, len;
    rst  = 1'b0;
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_tx", tx_o, 1'b1);
    rst = 1'b1;
    repeat (2 * BT) @(negedge clk);
    check("idle_tx", tx_o, 1'b1);

    // Echo, preceded by a short glitch that must be rejected as a false start.
    rx_i = 1'b0;
    repeat (BT / 4) @(negedge clk);
    rx_i = 1'b1;
    repeat (BT) @(negedge clk);
    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    send_pkt();
    finish_seg("echo");

    pkt_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt();
    finish_seg("add");

    pkt_q = '{8'hA0, 8'h00, 8'h0D, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
              8'h02, 8'h00, 8'h00, 8'h00, 8'h77};
    send_pkt();
    finish_seg("add_wrap");

    pkt_q = '{8'h88, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    send_pkt();
    finish_seg("mul");

    pkt_q = '{8'h88, 8'h00, 8'h04, 8'h00};
    send_pkt();
    finish_seg("mul_empty");

    pkt_q = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
    send_pkt();
    finish_seg("unk_echo");

    // Framing error on a payload byte: that byte vanishes, parser never sees it.
    pkt_q = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41};
    send_pkt();
    send_bits(8'h99, 1'b0);
    pkt_q = '{8'h42};
    send_pkt();
    finish_seg("frame_err");

    // Reset in the middle of a character inside an add payload.
    pkt_q = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
    send_pkt();
    rx_i = 1'b0;
    repeat (3 * BT) @(negedge clk);
    rst  = 1'b0;
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_mid_tx", tx_o, 1'b1);
    rst = 1'b1;
    stream_q.delete();
    repeat (BT) @(negedge clk);
    check("rst_after_tx", tx_o, 1'b1);
    finish_seg("rst_quiet");
    pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h33};
    send_pkt();
    finish_seg("rst_echo");

    // Randomized packets.
    for (int r = 0; r < 5; r++) begin
      case ($urandom_range(0, 3))
        0: op = 8'hEC;
        1: op = 8'hA0;
        2: op = 8'h88;
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op == 8'hEC || op == 8'hA0 || op == 8'h88) op = 8'h13;
        end
      endcase
      p   = $urandom_range(0, 9);
      len = p + 4;
      if ($urandom_range(0, 4) == 0) begin
        len = $urandom_range(0, 3);
        p   = 0;
      end
      pkt_q.delete();
      pkt_q.push_back(op);
      pkt_q.push_back(8'($urandom_range(0, 255)));
      pkt_q.push_back(8'(len));
      pkt_q.push_back(8'(len >> 8));
      for (int k = 0; k < p; k++) pkt_q.push_back(8'($urandom_range(0, 255)));
      send_pkt();
      finish_seg($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_alu_top.md
Name: uart_alu_top

Overview:
Top level of the iCE40 UART ALU. It receives 8N1 serial packets on rx_i, decodes a 4-byte header, and then does one of three things: echoes the payload, returns a 32-bit sum, or returns a 32-bit product of the payload operands. Results go out on tx_o. The block contains its own UART receiver, UART transmitter, packet parser/ALU and a small TX FIFO.

Parameters:
PRESCALE, 35, oversample divider; one bit time = 8*PRESCALE clk cycles (115200 baud at 32.26 MHz).
DATA_WIDTH, 8, UART character width.
TX_FIFO_DEPTH, 16, entries in the transmit byte FIFO (power of two).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, asynchronous, active-low (0 = in reset).
rx_i  input  1  serial input, idle high; pass through a 2-flop synchronizer before use.
tx_o  output  1  serial output, idle high.

Behaviour:
- Reset (rst=0), asynchronous and immediate:
  - tx_o=1, RX/TX FSMs idle, FIFO empty, parser in HDR0, accumulator=0.
  - Deassertion is sampled synchronously.
  - Reset mid-packet or mid-character aborts everything; no partial output.
- UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Bit time BT=8*PRESCALE cycles.
- RX:
  - Idle until the synchronized rx falls.
  - At BT/2, re-sample: if high, false start, return to idle.
  - Otherwise sample each data bit at successive BT intervals (mid-bit), then sample the stop bit.
  - Stop=1: emit a 1-cycle byte_valid with the data.
  - Stop=0 (frame error): discard the byte, parser unaffected, wait for the line to return high before re-arming.
- TX:
  - When idle and the FIFO is not empty, pop a byte and drive start, 8 data bits, stop, each for BT cycles.
  - Back-to-back bytes have no idle gap.
  - FIFO push while full drops the byte (pop has priority on a simultaneous push/pop).
- Packet format (bytes in order): OPCODE, RESERVED (ignored), LEN_LSB, LEN_MSB.
  - LEN = total packet length in bytes including the 4-byte header. LEN<4 is treated as 4.
  - Payload count P = LEN-4.
- Parser states: HDR0, HDR1, HDR2, HDR3, PAYLOAD, RESULT. Each received byte advances one step.
  - After HDR3, go to PAYLOAD if P>0; otherwise finish immediately.
- Opcode 0xEC (echo): each payload byte is pushed to the TX FIFO in the cycle after its receipt. No result bytes.
- Opcode 0xA0 (add):
  - Payload is taken as little-endian 32-bit operands.
  - acc starts at 0; acc = acc + operand mod 2^32 as each 4th byte completes.
- Opcode 0x88 (mul):
  - First complete operand loads acc; each later operand gives acc = lower 32 bits of acc*operand.
  - Zero complete operands gives result 0.
- Add/mul trailing bytes (P not a multiple of 4) are consumed and ignored.
- Add/mul result: after the last payload byte (or after HDR3 if P=0), RESULT pushes acc as 4 bytes, LSB first, on 4 consecutive cycles. Then return to HDR0 with acc=0.
- Any other opcode: consume and discard P payload bytes, no output.
- Multiplication may be multi-cycle, but must complete within BT cycles, before the next byte can arrive.

Test Plan:
- Echo: send EC 00 06 00 41 42 -> tx_o emits 41 then 42, valid 8N1 at BT=280 cycles; nothing else.
- Add: send A0 00 0C 00 01 00 00 00 02 00 00 00 -> tx emits 03 00 00 00.
- Add wrap plus trailing byte: send A0 00 0D 00 FF FF FF FF 02 00 00 00 77 -> tx emits 01 00 00 00.
- Mul: send 88 00 0C 00 03 00 00 00 05 00 00 00 -> tx emits 0F 00 00 00. Send 88 00 04 00 -> tx emits 00 00 00 00.
- Unknown opcode then echo: send 55 00 06 00 AA BB, then EC 00 05 00 5A -> only 5A emitted. A frame error injected on one echo payload byte drops only that byte.
- Reset: assert rst=0 mid-payload of an add packet, release -> tx_o stays 1 and no output. A following echo packet EC 00 05 00 33 -> tx emits 33.
